// File: rtl/prog_loader_if.sv
// Host byte-stream handshake and CPU RAM write port seen by the program loader.
// The loader uses the slave modport; the host/memory side uses master.
interface prog_loader_if #(
  parameter int ADDR_W = 4
);
  logic              host_strobe;
  logic [7:0]        host_data;
  logic              host_ack;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output host_strobe,
    output host_data,
    input  host_ack,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  host_strobe,
    input  host_data,
    output host_ack,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Host-side program loader: receives an {addr, cnt, data..., checksum} frame over a
// toggle-strobe handshake, writes the payload into CPU RAM and holds the CPU halted.
module prog_loader #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  prog_loader_if.slave bus,
  output logic         cpu_halt,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_ADDR,
    HDR_CNT,
    DATA,
    CHK,
    DONE
  } state_t;

  state_t state_q, state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_prev_q;
  logic                   new_byte;
  logic [7:0]             rx_byte;

  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [8:0]        cnt_q, cnt_n;
  logic [7:0]        sum_q, sum_n;
  logic              ack_q, ack_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] maddr_q, maddr_n;
  logic [7:0]        wdata_q, wdata_n;
  logic              halt_q, halt_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              err_q, err_n;

  // The previous-strobe register follows the synchronizer every cycle, so a toggle
  // always yields exactly one new_byte pulse whether or not the FSM consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.host_strobe};
      strobe_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign new_byte = sync_q[SYNC_STAGES-1] != strobe_prev_q;
  assign rx_byte  = bus.host_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      halt_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      cnt_q   <= cnt_n;
      sum_q   <= sum_n;
      ack_q   <= ack_n;
      we_q    <= we_n;
      maddr_q <= maddr_n;
      wdata_q <= wdata_n;
      halt_q  <= halt_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    cnt_n   = cnt_q;
    sum_n   = sum_q;
    ack_n   = ack_q;
    we_n    = 1'b0;
    maddr_n = maddr_q;
    wdata_n = wdata_q;
    halt_n  = halt_q;
    busy_n  = busy_q;
    done_n  = done_q;
    err_n   = err_q;

    unique case (state_q)
      IDLE: begin
        halt_n = 1'b0;
        busy_n = 1'b0;
        if (load_en) begin
          state_n = HDR_ADDR;
          halt_n  = 1'b1;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          err_n   = 1'b0;
          addr_n  = '0;
          cnt_n   = '0;
          sum_n   = '0;
        end
      end

      HDR_ADDR, HDR_CNT, DATA, CHK: begin
        // Abort wins over a coincident byte, so that byte is neither written nor acked.
        if (!load_en) begin
          state_n = IDLE;
          halt_n  = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b0;
          err_n   = 1'b1;
        end else if (new_byte) begin
          ack_n = ~ack_q;
          unique case (state_q)
            HDR_ADDR: begin
              addr_n  = rx_byte[ADDR_W-1:0];
              sum_n   = rx_byte;
              state_n = HDR_CNT;
            end
            HDR_CNT: begin
              cnt_n   = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
              sum_n   = sum_q + rx_byte;
              state_n = DATA;
            end
            DATA: begin
              we_n    = 1'b1;
              maddr_n = addr_q;
              wdata_n = rx_byte;
              addr_n  = addr_q + ADDR_W'(1);
              cnt_n   = cnt_q - 9'd1;
              sum_n   = sum_q + rx_byte;
              if (cnt_q == 9'd1) begin
                state_n = CHK;
              end
            end
            default: begin
              err_n   = rx_byte != sum_q;
              done_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = DONE;
            end
          endcase
        end
      end

      DONE: begin
        if (!load_en) begin
          state_n = IDLE;
          halt_n  = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.host_ack  = ack_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_halt      = halt_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

  // A RAM write may only happen while the CPU is held and a frame is open.
  assert property (@(posedge clk) disable iff (rst) we_q |-> (halt_q && busy_q));
  assert property (@(posedge clk) disable iff (rst) !(done_q && busy_q));

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven frames, randomized frames against
// a frame-level reference model, and hand-written abort/reset/256-byte sequences.
module tb_prog_loader;

  localparam int ADDR_W = 4;

  typedef struct {
    logic [7:0]  addr_b;
    logic [7:0]  cnt_b;
    logic [31:0] data_w;
    logic [7:0]  chk_b;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_en = 1'b0;
  logic cpu_halt, busy, done, err;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W+7:0] wr_q[$];
  logic [7:0]        tx_q[$];
  int                ack_cnt = 0;
  int                long_we = 0;
  logic              ack_prev = 1'b0;
  logic              we_prev = 1'b0;

  vec_t vecs[3];

  prog_loader_if #(.ADDR_W(ADDR_W)) bus();

  prog_loader #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .bus      (bus),
    .cpu_halt (cpu_halt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) wr_q.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.mem_we && we_prev) long_we++;
    if (bus.host_ack != ack_prev) ack_cnt++;
    ack_prev = bus.host_ack;
    we_prev  = bus.mem_we;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    logic a0;
    logic seen;
    a0   = bus.host_ack;
    seen = 1'b0;
    bus.host_data   = b;
    bus.host_strobe = ~bus.host_strobe;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (bus.host_ack != a0) seen = 1'b1;
    end
    checkOutput("ack_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int model_len();
    return (tx_q[1] == 8'd0) ? 256 : int'(tx_q[1]);
  endfunction

  function automatic logic model_err();
    int s = 0;
    int n = model_len();
    for (int i = 0; i < n + 2; i++) s += int'(tx_q[i]);
    return (s % 256) != int'(tx_q[n+2]);
  endfunction

  // Compares every RAM write since wr_base against the frame held in tx_q.
  task automatic check_writes(input string tag, input int wr_base, input int n);
    int a;
    int got;
    logic [7:0] a_byte;
    a_byte = tx_q[0];
    a = int'(a_byte) % (1 << ADDR_W);
    got = wr_q.size() - wr_base;
    checkOutput({tag, "_writes"}, got, n);
    for (int i = 0; i < n && i < got; i++)
      checkOutput({tag, "_wr"}, 32'(wr_q[wr_base+i]),
                  32'({ADDR_W'((a + i) % (1 << ADDR_W)), tx_q[2+i]}));
  endtask

  task automatic start_load(input string tag);
    load_en = 1'b1;
    tick(3);
    checkOutput({tag, "_open"}, {28'd0, busy, cpu_halt, done, err}, 32'b1100);
  endtask

  task automatic run_frame(input string tag, input logic exp_err);
    int wr_base;
    int ack_base;
    int n;
    n = model_len();
    start_load(tag);
    wr_base  = wr_q.size();
    ack_base = ack_cnt;
    foreach (tx_q[i]) applyStimulus(tx_q[i]);
    tick(1);
    checkOutput({tag, "_end"}, {28'd0, busy, cpu_halt, done, err}, {28'd0, 3'b011, exp_err});
    @(negedge clk);
    check_writes(tag, wr_base, n);
    checkOutput({tag, "_acks"}, ack_cnt - ack_base, tx_q.size());
    tick(1);
    load_en = 1'b0;
    tick(2);
    checkOutput({tag, "_release"}, {28'd0, busy, cpu_halt, done, err}, {28'd0, 3'b001, exp_err});
  endtask

  initial begin
    int wr_base;
    int ack_base;
    int n;
    logic [7:0] b;

    vecs[0] = '{8'h02, 8'h03, 32'h0033_2211, 8'h6B, 1'b0};
    vecs[1] = '{8'h0E, 8'h03, 32'h00A2_A1A0, 8'hF4, 1'b0};
    vecs[2] = '{8'h02, 8'h03, 32'h0033_2211, 8'h6C, 1'b1};

    bus.host_strobe = 1'b0;
    bus.host_data   = 8'h00;
    tick(3);
    checkOutput("reset_outputs",
                32'({bus.host_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_halt, busy, done, err}), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("[TB] idle strobes are ignored");
    wr_base  = wr_q.size();
    ack_base = ack_cnt;
    for (int i = 0; i < 3; i++) begin
      bus.host_data   = 8'h5A;
      bus.host_strobe = ~bus.host_strobe;
      tick(8);
    end
    checkOutput("idle_acks", ack_cnt - ack_base, 0);
    checkOutput("idle_writes", wr_q.size() - wr_base, 0);
    checkOutput("idle_status", {28'd0, busy, cpu_halt, done, err}, 32'd0);

    $display("[TB] table frames");
    for (int v = 0; v < 3; v++) begin
      tx_q.delete();
      tx_q.push_back(vecs[v].addr_b);
      tx_q.push_back(vecs[v].cnt_b);
      for (int i = 0; i < int'(vecs[v].cnt_b); i++) tx_q.push_back(vecs[v].data_w[8*i +: 8]);
      tx_q.push_back(vecs[v].chk_b);
      run_frame($sformatf("vec%0d", v), vecs[v].exp_err);
    end

    $display("[TB] random frames");
    for (int r = 0; r < 6; r++) begin
      int s;
      tx_q.delete();
      tx_q.push_back(8'($urandom));
      n = $urandom_range(6, 1);
      tx_q.push_back(8'(n));
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      s = 0;
      foreach (tx_q[i]) s += int'(tx_q[i]);
      tx_q.push_back(($urandom_range(1, 0) == 1) ? 8'(s) : 8'(s + $urandom_range(255, 1)));
      run_frame($sformatf("rnd%0d", r), model_err());
    end

    $display("[TB] abort after second data byte");
    tx_q.delete();
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h03);
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    start_load("abort");
    wr_base = wr_q.size();
    foreach (tx_q[i]) applyStimulus(tx_q[i]);
    tick(1);
    load_en = 1'b0;
    tick(1);
    checkOutput("abort_status", {28'd0, busy, cpu_halt, done, err}, 32'b0001);
    @(negedge clk);
    check_writes("abort", wr_base, 2);
    tick(2);
    start_load("abort_reload");
    load_en = 1'b0;
    tick(2);

    $display("[TB] count 0 means 256 bytes");
    begin
      int s;
      tx_q.delete();
      tx_q.push_back(8'h05);
      tx_q.push_back(8'h00);
      for (int i = 0; i < 256; i++) tx_q.push_back(8'($urandom));
      s = 0;
      foreach (tx_q[i]) s += int'(tx_q[i]);
      tx_q.push_back(8'(s));
      run_frame("cnt256", 1'b0);
    end

    $display("[TB] reset mid-stream");
    start_load("rstmid");
    applyStimulus(8'h03);
    applyStimulus(8'h08);
    applyStimulus(8'hC1);
    applyStimulus(8'hC2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_outputs",
                32'({bus.host_ack, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_halt, busy, done, err}), 32'd0);
    @(negedge clk);
    wr_base = wr_q.size();
    tick(3);
    load_en = 1'b0;
    rst = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      bus.host_data   = b;
      bus.host_strobe = ~bus.host_strobe;
      tick(8);
    end
    @(negedge clk);
    checkOutput("rstmid_no_writes", wr_q.size() - wr_base, 0);
    checkOutput("rstmid_status", {28'd0, busy, cpu_halt, done, err}, 32'd0);

    checkOutput("we_pulse_len", long_we, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
